// File: rtl/int_rs_issue.sv
// Integer reservation station: collapsing age-ordered queue that wakes operands
// from the completion broadcast and issues the oldest ready op, one per cycle.
module int_rs_issue #(
    parameter int ENTRIES = 4,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             dispatch_valid,
    output logic             dispatch_ready,
    input  logic [3:0]       in_aluop,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    input  logic             in_op1_valid,
    input  logic             in_op2_valid,
    input  logic [4:0]       in_op1_tag,
    input  logic [4:0]       in_op2_tag,
    input  logic             cdb_valid,
    input  logic [4:0]       cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic             issue_stall,
    output logic             issue_start,
    output logic [75:0]      issue_rs,
    output logic [CNT_W-1:0] count
);

    logic [3:0]       aluop_q   [ENTRIES];
    logic [4:0]       rd_q      [ENTRIES];
    logic [31:0]      op1_q     [ENTRIES];
    logic [31:0]      op2_q     [ENTRIES];
    logic             op1_v_q   [ENTRIES];
    logic             op2_v_q   [ENTRIES];
    logic [4:0]       op1_tag_q [ENTRIES];
    logic [4:0]       op2_tag_q [ENTRIES];
    logic [CNT_W-1:0] count_q;
    logic             start_q;
    logic [75:0]      rs_q;

    logic [3:0]       aluop_d   [ENTRIES];
    logic [4:0]       rd_d      [ENTRIES];
    logic [31:0]      op1_d     [ENTRIES];
    logic [31:0]      op2_d     [ENTRIES];
    logic             op1_v_d   [ENTRIES];
    logic             op2_v_d   [ENTRIES];
    logic [4:0]       op1_tag_d [ENTRIES];
    logic [4:0]       op2_tag_d [ENTRIES];
    logic [CNT_W-1:0] count_d;
    logic             start_d;
    logic [75:0]      rs_d;

    // Post-wakeup view of every slot; the extra top element feeds the shift of the last slot.
    logic [3:0]       w_aluop   [ENTRIES+1];
    logic [4:0]       w_rd      [ENTRIES+1];
    logic [31:0]      w_op1     [ENTRIES+1];
    logic [31:0]      w_op2     [ENTRIES+1];
    logic             w_op1_v   [ENTRIES+1];
    logic             w_op2_v   [ENTRIES+1];
    logic [4:0]       w_op1_tag [ENTRIES+1];
    logic [4:0]       w_op2_tag [ENTRIES+1];

    logic             sel_found_s;
    logic [CNT_W-1:0] sel_idx_s;
    logic [75:0]      sel_rs_s;
    logic             issue_fire_s;
    logic             dispatch_fire_s;
    logic             cdb_hit_s;
    logic [CNT_W-1:0] wr_idx_s;
    logic             in_op1_v_s;
    logic             in_op2_v_s;
    logic [31:0]      in_op1_val_s;
    logic [31:0]      in_op2_val_s;

    assign dispatch_ready  = (count_q != CNT_W'(ENTRIES));
    assign issue_start     = start_q;
    assign issue_rs        = rs_q;
    assign count           = count_q;
    assign dispatch_fire_s = dispatch_valid & dispatch_ready;
    assign cdb_hit_s       = cdb_valid & (cdb_tag != 5'd0);
    assign issue_fire_s    = sel_found_s & ~issue_stall;

    // Oldest-ready selection on registered state; descending scan lets the lowest index win.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        sel_rs_s    = 76'd0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < count_q) && op1_v_q[i] && op2_v_q[i]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = CNT_W'(i);
                sel_rs_s    = {aluop_q[i], rd_q[i], 3'b000, op1_q[i], op2_q[i]};
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Operand wakeup from the completion broadcast, applied before any shifting.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_aluop[i]   = aluop_q[i];
            w_rd[i]      = rd_q[i];
            w_op1_tag[i] = op1_tag_q[i];
            w_op2_tag[i] = op2_tag_q[i];
            w_op1[i]     = op1_q[i];
            w_op2[i]     = op2_q[i];
            w_op1_v[i]   = op1_v_q[i];
            w_op2_v[i]   = op2_v_q[i];
            if (cdb_hit_s && (CNT_W'(i) < count_q) && !op1_v_q[i] && (op1_tag_q[i] == cdb_tag)) begin
                w_op1[i]   = cdb_value;
                w_op1_v[i] = 1'b1;
            end else begin
                w_op1_v[i] = op1_v_q[i];
            end
            if (cdb_hit_s && (CNT_W'(i) < count_q) && !op2_v_q[i] && (op2_tag_q[i] == cdb_tag)) begin
                w_op2[i]   = cdb_value;
                w_op2_v[i] = 1'b1;
            end else begin
                w_op2_v[i] = op2_v_q[i];
            end
        end
        w_aluop[ENTRIES]   = 4'd0;
        w_rd[ENTRIES]      = 5'd0;
        w_op1[ENTRIES]     = 32'd0;
        w_op2[ENTRIES]     = 32'd0;
        w_op1_v[ENTRIES]   = 1'b0;
        w_op2_v[ENTRIES]   = 1'b0;
        w_op1_tag[ENTRIES] = 5'd0;
        w_op2_tag[ENTRIES] = 5'd0;
    end

    // Incoming operands can be satisfied by a broadcast in the same cycle.
    always_comb begin
        in_op1_v_s   = in_op1_valid;
        in_op2_v_s   = in_op2_valid;
        in_op1_val_s = in_op1;
        in_op2_val_s = in_op2;
        if (!in_op1_valid && cdb_hit_s && (in_op1_tag == cdb_tag)) begin
            in_op1_v_s   = 1'b1;
            in_op1_val_s = cdb_value;
        end else begin
            in_op1_v_s   = in_op1_valid;
        end
        if (!in_op2_valid && cdb_hit_s && (in_op2_tag == cdb_tag)) begin
            in_op2_v_s   = 1'b1;
            in_op2_val_s = cdb_value;
        end else begin
            in_op2_v_s   = in_op2_valid;
        end
    end

    // Collapse above the issued slot, place the new op, update count and issue register.
    always_comb begin
        wr_idx_s = issue_fire_s ? (count_q - CNT_W'(1)) : count_q;
        for (int i = 0; i < ENTRIES; i++) begin
            if (issue_fire_s && (CNT_W'(i) >= sel_idx_s)) begin
                aluop_d[i]   = w_aluop[i+1];
                rd_d[i]      = w_rd[i+1];
                op1_d[i]     = w_op1[i+1];
                op2_d[i]     = w_op2[i+1];
                op1_v_d[i]   = w_op1_v[i+1];
                op2_v_d[i]   = w_op2_v[i+1];
                op1_tag_d[i] = w_op1_tag[i+1];
                op2_tag_d[i] = w_op2_tag[i+1];
            end else begin
                aluop_d[i]   = w_aluop[i];
                rd_d[i]      = w_rd[i];
                op1_d[i]     = w_op1[i];
                op2_d[i]     = w_op2[i];
                op1_v_d[i]   = w_op1_v[i];
                op2_v_d[i]   = w_op2_v[i];
                op1_tag_d[i] = w_op1_tag[i];
                op2_tag_d[i] = w_op2_tag[i];
            end
            if (dispatch_fire_s && (CNT_W'(i) == wr_idx_s)) begin
                aluop_d[i]   = in_aluop;
                rd_d[i]      = in_rd;
                op1_d[i]     = in_op1_val_s;
                op2_d[i]     = in_op2_val_s;
                op1_v_d[i]   = in_op1_v_s;
                op2_v_d[i]   = in_op2_v_s;
                op1_tag_d[i] = in_op1_tag;
                op2_tag_d[i] = in_op2_tag;
            end else begin
                aluop_d[i]   = aluop_d[i];
            end
            if (flush) begin
                op1_v_d[i] = 1'b0;
                op2_v_d[i] = 1'b0;
            end else begin
                op1_v_d[i] = op1_v_d[i];
            end
        end
        count_d = count_q + CNT_W'(dispatch_fire_s) - CNT_W'(issue_fire_s);
        start_d = issue_fire_s;
        rs_d    = issue_fire_s ? sel_rs_s : rs_q;
        if (flush) begin
            count_d = '0;
            start_d = 1'b0;
            rs_d    = 76'd0;
        end else begin
            start_d = start_d;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            start_q <= 1'b0;
            rs_q    <= 76'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                aluop_q[i]   <= 4'd0;
                rd_q[i]      <= 5'd0;
                op1_q[i]     <= 32'd0;
                op2_q[i]     <= 32'd0;
                op1_v_q[i]   <= 1'b0;
                op2_v_q[i]   <= 1'b0;
                op1_tag_q[i] <= 5'd0;
                op2_tag_q[i] <= 5'd0;
            end
        end else begin
            count_q <= count_d;
            start_q <= start_d;
            rs_q    <= rs_d;
            for (int i = 0; i < ENTRIES; i++) begin
                aluop_q[i]   <= aluop_d[i];
                rd_q[i]      <= rd_d[i];
                op1_q[i]     <= op1_d[i];
                op2_q[i]     <= op2_d[i];
                op1_v_q[i]   <= op1_v_d[i];
                op2_v_q[i]   <= op2_v_d[i];
                op1_tag_q[i] <= op1_tag_d[i];
                op2_tag_q[i] <= op2_tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_int_rs_issue.sv
// Directed self-checking bench for int_rs_issue (ENTRIES=4, CNT_W=3).
module tb_int_rs_issue;

    logic        clk = 1'b0;
    logic        reset, flush, dispatch_valid, dispatch_ready;
    logic [3:0]  in_aluop;
    logic [4:0]  in_rd, in_op1_tag, in_op2_tag, cdb_tag;
    logic [31:0] in_op1, in_op2, cdb_value;
    logic        in_op1_valid, in_op2_valid, cdb_valid, issue_stall, issue_start;
    logic [75:0] issue_rs;
    logic [2:0]  count;
    int          total = 0;
    int          bad = 0;

    int_rs_issue #(.ENTRIES(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .in_aluop(in_aluop), .in_rd(in_rd), .in_op1(in_op1), .in_op2(in_op2),
        .in_op1_valid(in_op1_valid), .in_op2_valid(in_op2_valid),
        .in_op1_tag(in_op1_tag), .in_op2_tag(in_op2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_stall(issue_stall), .issue_start(issue_start),
        .issue_rs(issue_rs), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [75:0] rs_of(input logic [3:0] a, input logic [4:0] rd,
                                          input logic [31:0] o1, input logic [31:0] o2);
        rs_of = {a, rd, 3'b000, o1, o2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; dispatch_valid = 1'b0; in_aluop = 4'd0; in_rd = 5'd0;
        in_op1 = 32'd0; in_op2 = 32'd0; in_op1_valid = 1'b0; in_op2_valid = 1'b0;
        in_op1_tag = 5'd0; in_op2_tag = 5'd0; cdb_valid = 1'b0; cdb_tag = 5'd0;
        cdb_value = 32'd0; issue_stall = 1'b0;
    endtask

    task automatic set_disp(input logic [3:0] a, input logic [4:0] rd,
                            input logic [31:0] o1, input logic v1, input logic [4:0] t1,
                            input logic [31:0] o2, input logic v2, input logic [4:0] t2);
        dispatch_valid = 1'b1; in_aluop = a; in_rd = rd;
        in_op1 = o1; in_op1_valid = v1; in_op1_tag = t1;
        in_op2 = o2; in_op2_valid = v2; in_op2_tag = t2;
    endtask

    task automatic set_cdb(input logic [4:0] t, input logic [31:0] v);
        cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle();
        tick(); tick();
        reset = 1'b0;
        tick();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (issue_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%0b want=0", issue_start); end
        total++; if (issue_rs !== 76'd0) begin bad++; $display("FAIL reset_rs got=%h want=0", issue_rs); end
        total++; if (dispatch_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", dispatch_ready); end
    endtask

    task automatic test_basic();
        set_disp(4'd0, 5'd3, 32'd5, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0);
        tick(); idle();
        total++; if (count !== 3'd1) begin bad++; $display("FAIL basic_count1 got=%0d want=1", count); end
        total++; if (issue_start !== 1'b0) begin bad++; $display("FAIL basic_early got=%0b want=0", issue_start); end
        tick();
        total++; if (issue_start !== 1'b1) begin bad++; $display("FAIL basic_start got=%0b want=1", issue_start); end
        total++; if (issue_rs !== rs_of(4'd0, 5'd3, 32'd5, 32'd7)) begin bad++; $display("FAIL basic_rs got=%h want=%h", issue_rs, rs_of(4'd0, 5'd3, 32'd5, 32'd7)); end
        tick();
        total++; if (issue_start !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%0b want=0", issue_start); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL basic_count0 got=%0d want=0", count); end
        total++; if (issue_rs !== rs_of(4'd0, 5'd3, 32'd5, 32'd7)) begin bad++; $display("FAIL basic_hold got=%h", issue_rs); end
    endtask

    task automatic test_wakeup();
        set_disp(4'd2, 5'd4, 32'd0, 1'b0, 5'd9, 32'd1, 1'b1, 5'd0);
        tick(); idle();
        tick();
        set_cdb(5'd0, 32'h10);
        tick(); idle();
        total++; if (issue_start !== 1'b0) begin bad++; $display("FAIL wake_tag0_a got=%0b want=0", issue_start); end
        tick();
        total++; if (issue_start !== 1'b0) begin bad++; $display("FAIL wake_tag0_b got=%0b want=0", issue_start); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL wake_count got=%0d want=1", count); end
        set_cdb(5'd9, 32'h10);
        tick(); idle();
        total++; if (issue_start !== 1'b0) begin bad++; $display("FAIL wake_same_cycle got=%0b want=0", issue_start); end
        tick();
        total++; if (issue_start !== 1'b1) begin bad++; $display("FAIL wake_start got=%0b want=1", issue_start); end
        total++; if (issue_rs !== rs_of(4'd2, 5'd4, 32'h10, 32'd1)) begin bad++; $display("FAIL wake_rs got=%h want=%h", issue_rs, rs_of(4'd2, 5'd4, 32'h10, 32'd1)); end
    endtask

    task automatic test_age();
        issue_stall = 1'b1;
        set_disp(4'd1, 5'd10, 32'd0, 1'b0, 5'd2, 32'h22, 1'b1, 5'd0);
        tick();
        set_disp(4'd1, 5'd11, 32'd1, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0);
        tick();
        set_disp(4'd1, 5'd12, 32'd3, 1'b1, 5'd0, 32'd4, 1'b1, 5'd0);
        tick(); idle();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL age_count3 got=%0d want=3", count); end
        tick();
        total++; if (issue_rs !== rs_of(4'd1, 5'd11, 32'd1, 32'd2) || issue_start !== 1'b1) begin bad++; $display("FAIL age_B got=%h want=%h", issue_rs, rs_of(4'd1, 5'd11, 32'd1, 32'd2)); end
        total++; if (count !== 3'd2) begin bad++; $display("FAIL age_count2 got=%0d want=2", count); end
        tick();
        total++; if (issue_rs !== rs_of(4'd1, 5'd12, 32'd3, 32'd4) || issue_start !== 1'b1) begin bad++; $display("FAIL age_C got=%h want=%h", issue_rs, rs_of(4'd1, 5'd12, 32'd3, 32'd4)); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL age_count1 got=%0d want=1", count); end
        tick();
        total++; if (issue_start !== 1'b0) begin bad++; $display("FAIL age_idle got=%0b want=0", issue_start); end
        set_cdb(5'd2, 32'h77);
        tick(); idle();
        tick();
        total++; if (issue_rs !== rs_of(4'd1, 5'd10, 32'h77, 32'h22) || issue_start !== 1'b1) begin bad++; $display("FAIL age_A got=%h want=%h", issue_rs, rs_of(4'd1, 5'd10, 32'h77, 32'h22)); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL age_count0 got=%0d want=0", count); end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            set_disp(4'd3, 5'(20 + k), 32'd0, 1'b0, 5'(24 + k), 32'(256 + k), 1'b1, 5'd0);
            tick();
        end
        idle();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", count); end
        total++; if (dispatch_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b want=0", dispatch_ready); end
        set_disp(4'd3, 5'd30, 32'd1, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0);
        tick(); idle();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_drop got=%0d want=4", count); end
        tick();
        total++; if (issue_start !== 1'b0) begin bad++; $display("FAIL full_noissue got=%0b want=0", issue_start); end
        set_cdb(5'd26, 32'h55);
        tick(); idle();
        tick();
        total++; if (issue_rs !== rs_of(4'd3, 5'd22, 32'h55, 32'h102) || issue_start !== 1'b1) begin bad++; $display("FAIL full_slot2 got=%h want=%h", issue_rs, rs_of(4'd3, 5'd22, 32'h55, 32'h102)); end
        total++; if (count !== 3'd3 || dispatch_ready !== 1'b1) begin bad++; $display("FAIL full_after got=%0d/%0b want=3/1", count, dispatch_ready); end
        set_cdb(5'd27, 32'h66);
        tick(); idle();
        tick();
        total++; if (issue_rs !== rs_of(4'd3, 5'd23, 32'h66, 32'h103) || issue_start !== 1'b1) begin bad++; $display("FAIL full_shift got=%h want=%h", issue_rs, rs_of(4'd3, 5'd23, 32'h66, 32'h103)); end
        flush = 1'b1;
        tick(); idle();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL full_flush got=%0d want=0", count); end
    endtask

    task automatic test_simul();
        issue_stall = 1'b1;
        set_disp(4'd5, 5'd1, 32'h11, 1'b1, 5'd0, 32'h12, 1'b1, 5'd0);
        tick();
        issue_stall = 1'b0;
        set_disp(4'd6, 5'd2, 32'h21, 1'b1, 5'd0, 32'd0, 1'b0, 5'd6);
        set_cdb(5'd6, 32'hAB);
        tick(); idle();
        total++; if (issue_rs !== rs_of(4'd5, 5'd1, 32'h11, 32'h12) || issue_start !== 1'b1) begin bad++; $display("FAIL simul_X got=%h want=%h", issue_rs, rs_of(4'd5, 5'd1, 32'h11, 32'h12)); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL simul_count got=%0d want=1", count); end
        tick();
        total++; if (issue_rs !== rs_of(4'd6, 5'd2, 32'h21, 32'hAB) || issue_start !== 1'b1) begin bad++; $display("FAIL simul_bypass got=%h want=%h", issue_rs, rs_of(4'd6, 5'd2, 32'h21, 32'hAB)); end
        issue_stall = 1'b1;
        set_disp(4'd7, 5'd3, 32'h31, 1'b1, 5'd0, 32'h32, 1'b1, 5'd0);
        tick();
        dispatch_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if (issue_start !== 1'b0) begin bad++; $display("FAIL stall_%0d got=%0b want=0", k, issue_start); end
            if (k < 2) tick();
        end
        issue_stall = 1'b0;
        tick();
        total++; if (issue_rs !== rs_of(4'd7, 5'd3, 32'h31, 32'h32) || issue_start !== 1'b1) begin bad++; $display("FAIL stall_resume got=%h want=%h", issue_rs, rs_of(4'd7, 5'd3, 32'h31, 32'h32)); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL stall_count got=%0d want=0", count); end
    endtask

    task automatic test_flush_reset();
        issue_stall = 1'b1;
        set_disp(4'd8, 5'd5, 32'd1, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0); tick();
        set_disp(4'd8, 5'd6, 32'd0, 1'b0, 5'd15, 32'd3, 1'b1, 5'd0); tick();
        set_disp(4'd8, 5'd7, 32'd0, 1'b0, 5'd15, 32'd4, 1'b1, 5'd0); tick();
        set_disp(4'd8, 5'd8, 32'd0, 1'b0, 5'd16, 32'd5, 1'b1, 5'd0); tick();
        idle();
        tick();
        total++; if (issue_start !== 1'b1 || count !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0b/%0d want=1/3", issue_start, count); end
        flush = 1'b1;
        set_disp(4'd8, 5'd9, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0);
        set_cdb(5'd15, 32'h99);
        tick(); idle();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", count); end
        total++; if (issue_start !== 1'b0) begin bad++; $display("FAIL flush_start got=%0b want=0", issue_start); end
        total++; if (issue_rs !== 76'd0) begin bad++; $display("FAIL flush_rs got=%h want=0", issue_rs); end
        tick();
        total++; if (issue_start !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL flush_after got=%0b/%0d want=0/0", issue_start, count); end
        set_disp(4'd9, 5'd9, 32'h91, 1'b1, 5'd0, 32'h92, 1'b1, 5'd0); tick();
        set_disp(4'd9, 5'd10, 32'd0, 1'b0, 5'd17, 32'd1, 1'b1, 5'd0); tick();
        idle();
        total++; if (issue_start !== 1'b1 || count !== 3'd1) begin bad++; $display("FAIL areset_pre got=%0b/%0d want=1/1", issue_start, count); end
        #2 reset = 1'b1;
        #1;
        total++; if (issue_start !== 1'b0) begin bad++; $display("FAIL areset_start got=%0b want=0", issue_start); end
        total++; if (issue_rs !== 76'd0) begin bad++; $display("FAIL areset_rs got=%h want=0", issue_rs); end
        total++; if (count !== 3'd0 || dispatch_ready !== 1'b1) begin bad++; $display("FAIL areset_count got=%0d/%0b want=0/1", count, dispatch_ready); end
        tick();
        reset = 1'b0;
        tick();
        total++; if (count !== 3'd0 || issue_start !== 1'b0) begin bad++; $display("FAIL areset_after got=%0d/%0b want=0/0", count, issue_start); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_age();
        test_full();
        test_simul();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_rs_issue.md
Name: int_rs_issue

Overview:
- Integer reservation station: the issuing end of the `{aluop, rd, op1, op2}` execution-unit interface.
- Buffers dispatched integer ops until both source operands are valid, snooping the completion broadcast for missing values.
- Issues the oldest ready op, one per cycle, as a registered `start`/76-bit `rs` pair to the integer execution unit.
- Sits between decode/rename dispatch and the integer execution unit.

Parameters:
- `ENTRIES`, default 4, number of station slots (2..16).
- `CNT_W`, default 3, width of the occupancy count; must satisfy 2^CNT_W > ENTRIES.

Ports:
- `clk`  input  1  clock, all state on rising edge
- `reset`  input  1  asynchronous, active-high
- `flush`  input  1  synchronous clear of all entries and of the issue register
- `dispatch_valid`  input  1  new op present this cycle
- `dispatch_ready`  output  1  station can accept an op this cycle
- `in_aluop`  input  4  ALU opcode, same encoding as the execution unit
- `in_rd`  input  5  destination register / tag
- `in_op1`, `in_op2`  input  32 each  operand values, meaningful when the matching valid bit is set
- `in_op1_valid`, `in_op2_valid`  input  1 each  operand already available
- `in_op1_tag`, `in_op2_tag`  input  5 each  producer tag when the operand is not valid
- `cdb_valid`  input  1  completion broadcast valid
- `cdb_tag`  input  5  completing rd
- `cdb_value`  input  32  completing result
- `issue_stall`  input  1  execution unit cannot accept; suppresses selection
- `issue_start`  output  1  registered; one-cycle pulse per issued op
- `issue_rs`  output  76  registered `{aluop[75:72], rd[71:67], op1[63:32]... }`, i.e. `{aluop, rd, op1, op2}` packed MSB first
- `count`  output  `CNT_W`  number of occupied entries

Behaviour:
- **Reset** (async) and **flush** (sync): all entry valid bits cleared, `count` = 0, `issue_start` = 0, `issue_rs` = 0, `dispatch_ready` = 1.
  - `flush` has priority over dispatch, issue and wakeup in the same cycle.
- **Storage** is a collapsing queue. Slot 0 is always the oldest; occupied slots are contiguous from 0 to `count`-1.
  - Per slot: `aluop`, `rd`, `op1`, `op1_v`, `op1_tag`, `op2`, `op2_v`, `op2_tag`.
- **Ready:** a slot is ready when occupied and `op1_v` & `op2_v` are set, evaluated on registered state.
  - An operand woken this cycle counts as ready next cycle; no same-cycle wakeup-to-issue.
- **Select:** if `issue_stall` = 0, the lowest-index ready slot is selected.
  - On the next edge: `issue_rs` <= that slot's packed fields, `issue_start` <= 1, and the slot is removed.
  - Slots above it shift down by one, preserving order.
  - With no ready slot, or with `issue_stall` = 1, `issue_start` <= 0 and `issue_rs` holds its previous value.
- **Issue latency:** an op dispatched with both operands valid at edge N is issuable from cycle N. `issue_start` rises at edge N+1 at the earliest.
- **Wakeup:** when `cdb_valid` = 1 and `cdb_tag` != 0, every occupied slot with `opX_v` = 0 and `opX_tag` == `cdb_tag` captures `cdb_value` and sets `opX_v`.
  - Both operands of one slot may wake in the same cycle.
  - Wakeup applies to a slot even when it shifts down in that cycle; the written value follows the slot.
  - `cdb_tag` = 0 broadcasts are ignored.
- **Dispatch bypass:** an incoming op whose `in_opX_valid` = 0 and `in_opX_tag` matches a same-cycle valid broadcast is stored with `cdb_value` and valid = 1.
- **Accept:** `dispatch_ready` = (`count` != `ENTRIES`), combinational from registered `count`.
  - Dispatch occurs when `dispatch_valid` & `dispatch_ready`.
  - `dispatch_valid` while not ready is ignored; no state change.
  - A full station does not accept even if an issue frees a slot that cycle.
- **Placement:** a new op is written at slot (`count` - 1) if an issue occurs the same cycle, else at slot `count`.
- **Count:** `count` next = `count` + dispatch − issue. Simultaneous dispatch and issue leave `count` unchanged.
- No ordering between slots is assumed beyond age; the oldest-ready policy is fixed.

Test Plan:
- **Basic issue:** reset, dispatch ADD (aluop 0, rd 3, op1 5, op2 7, both valid) → next cycle `issue_start` = 1, `issue_rs` = {0, 3, 5, 7}; then `issue_start` = 0, `count` = 0.
- **Wakeup:** dispatch rd 4 with op1 waiting on tag 9, op2 = 1; two cycles later broadcast tag 9 value 0x10 → `issue_start` one cycle after the wakeup edge, `issue_rs` op1 = 0x10. Broadcast tag 0 value 0x10 instead → no wakeup.
- **Age order:** dispatch A (waiting on tag 2), B (ready), C (ready) → B issues, then C. After tag 2 broadcasts, A issues; `count` steps 3, 2, 1, 0 accordingly.
- **Full/backpressure:** `ENTRIES` = 4, fill with 4 waiting ops → `dispatch_ready` = 0. A 5th `dispatch_valid` is dropped; `count` stays 4. Wake slot 2 → it issues; slot 3 shifts to 2; `dispatch_ready` = 1 next cycle.
- **Simultaneous events:** same cycle apply dispatch (op2 tag 6 not valid), issue of slot 0, and broadcast tag 6 value 0xAB → new entry stored at `count` − 1 with op2 = 0xAB valid; `count` unchanged. Set `issue_stall` = 1 for 3 cycles → no `issue_start` during the stall; issue resumes the cycle after it drops.
- **Reset/flush mid-operation:** with 3 entries and `issue_start` high, assert `flush` → next cycle `count` = 0, `issue_start` = 0, `issue_rs` = 0. Assert `reset` asynchronously mid-cycle → outputs clear immediately, without waiting for a clock edge.
